seq_alu: RTL

Multi-cycle ALU execution unit that consumes the 3-bit ALUControl code produced by the ALU decoder and returns a result over a valid/ready handshake. Add, sub, slt, xor, or and and complete in one cycle. Shifts are iterative, one bit position per cycle, which keeps the area low. The block sits between the decode/operand-select stage and the writeback stage of the multi-cycle RV32I datapath variant.

---
 rtl/seq_alu_if.sv | 26 ++
 rtl/seq_alu.sv | 111 +++++++++++
 2 files changed

// File: rtl/seq_alu_if.sv
// Request/response bundle for seq_alu: operand request with valid/ready in,
// registered result with valid/ready out.
interface seq_alu_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [2:0]       alucontrol;
  logic             sra;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             zero;

  modport master (
    output in_valid, a, b, alucontrol, sra, out_ready,
    input  in_ready, out_valid, result, zero
  );

  modport slave (
    input  in_valid, a, b, alucontrol, sra, out_ready,
    output in_ready, out_valid, result, zero
  );
endinterface

// File: rtl/seq_alu.sv
// Multi-cycle ALU: logic/arithmetic ops finish on the accept edge, shifts
// advance one bit per cycle in place inside the result register.
module seq_alu #(
  parameter int WIDTH = 32
) (
  input  logic      clk,
  input  logic      reset,
  seq_alu_if.slave  bus
);
  localparam int SHW = $clog2(WIDTH);

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_SL  = 3'b010;
  localparam logic [2:0] ALU_SLT = 3'b011;
  localparam logic [2:0] ALU_XOR = 3'b100;
  localparam logic [2:0] ALU_SR  = 3'b101;
  localparam logic [2:0] ALU_OR  = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b111;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] result_reg, result_next;
  logic [SHW-1:0]   cnt_reg, cnt_next;
  logic             left_reg, left_next;
  logic             arith_reg, arith_next;

  logic [WIDTH-1:0] alu_out;
  logic [SHW-1:0]   shamt;
  logic             is_shift;
  logic             fill_bit;

  assign shamt    = bus.b[SHW-1:0];
  assign is_shift = (bus.alucontrol == ALU_SL) || (bus.alucontrol == ALU_SR);
  assign fill_bit = arith_reg & result_reg[WIDTH-1];

  // Shift ops load the unshifted operand; the SHIFT state does the rest.
  always_comb begin
    alu_out = bus.a;
    case (bus.alucontrol)
      ALU_ADD: alu_out = bus.a + bus.b;
      ALU_SUB: alu_out = bus.a - bus.b;
      ALU_SLT: alu_out = {{(WIDTH-1){1'b0}}, ($signed(bus.a) < $signed(bus.b))};
      ALU_XOR: alu_out = bus.a ^ bus.b;
      ALU_OR:  alu_out = bus.a | bus.b;
      ALU_AND: alu_out = bus.a & bus.b;
      default: alu_out = bus.a;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg  <= IDLE;
      result_reg <= '0;
      cnt_reg    <= '0;
      left_reg   <= 1'b0;
      arith_reg  <= 1'b0;
    end else begin
      state_reg  <= state_next;
      result_reg <= result_next;
      cnt_reg    <= cnt_next;
      left_reg   <= left_next;
      arith_reg  <= arith_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    result_next = result_reg;
    cnt_next    = cnt_reg;
    left_next   = left_reg;
    arith_next  = arith_reg;

    case (state_reg)
      IDLE: begin
        if (bus.in_valid) begin
          result_next = alu_out;
          left_next   = (bus.alucontrol == ALU_SL);
          arith_next  = bus.sra;
          if (is_shift && (shamt != '0)) begin
            cnt_next   = shamt;
            state_next = SHIFT;
          end else begin
            state_next = DONE;
          end
        end
      end
      SHIFT: begin
        if (left_reg)
          result_next = {result_reg[WIDTH-2:0], 1'b0};
        else
          result_next = {fill_bit, result_reg[WIDTH-1:1]};
        cnt_next = cnt_reg - SHW'(1);
        // Leaving on cnt == 1 lands out_valid exactly shamt edges after accept.
        if (cnt_reg == SHW'(1))
          state_next = DONE;
      end
      DONE: begin
        if (bus.out_ready)
          state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign bus.in_ready  = (state_reg == IDLE);
  assign bus.out_valid = (state_reg == DONE);
  assign bus.result    = result_reg;
  assign bus.zero      = (result_reg == '0);
endmodule
